// File: rtl/cdc_lib_pkg.sv
// Shared definitions for the async-FIFO arbiters: arbiter state encoding and a
// constant-width helper usable in parameter expressions.
package cdc_lib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2,
    ST_PAD   = 2'd3
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_win,
// wrapping. Shared by the write-side n2one and read-side one2n arbiters.
module rr_pick #(
  parameter int P_REQ     = 4,
  parameter int P_SEL_MSB = 1
) (
  input  logic [P_REQ-1:0]   req,
  input  logic [P_SEL_MSB:0] last_win,
  output logic [P_REQ-1:0]   pick_oh,
  output logic [P_SEL_MSB:0] pick_idx
);

  localparam int SW = P_SEL_MSB + 1;

  logic [SW-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    pick_oh  = '0;
    pick_idx = '0;
    cand     = '0;
    // Scan from the farthest candidate to the nearest; the nearest set request overwrites last.
    for (int i = P_REQ; i >= 1; i--) begin
      cand = SW'((int'(last_win) + i) % P_REQ);
      if (req[cand]) begin
        pick_oh       = '0;
        pick_oh[cand] = 1'b1;
        pick_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/wr_arb_n2one.sv
// Round-robin write-port arbiter for the n2one async FIFO: one grant per packed word.
// Optional macro WR_ARB_N2ONE_PAD_EN adds o_pad and pads out words stalled for P_ABORT_CYC cycles.
module wr_arb_n2one
  import cdc_lib_pkg::*;
#(
  parameter int P_REQ       = 4,
  parameter int P_SEL_MSB   = 1,
  parameter int P_UNITS     = 4,
  parameter int P_CNT_MSB   = 1
`ifdef WR_ARB_N2ONE_PAD_EN
  ,
  parameter int P_ABORT_CYC = 8
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [P_REQ-1:0]   i_req,
  input  logic               i_full,
  output logic [P_REQ-1:0]   o_gnt,
  output logic [P_SEL_MSB:0] o_sel,
  output logic [P_REQ-1:0]   o_ack,
  output logic               o_inc,
  output logic               o_word_done,
  output logic               o_busy
`ifdef WR_ARB_N2ONE_PAD_EN
  ,
  output logic               o_pad
`endif
);

  localparam int SW = P_SEL_MSB + 1;
  localparam int CW = P_CNT_MSB + 1;

  arb_state_t        state, state_nxt;
  logic [CW-1:0]     unit_cnt;
  logic [SW-1:0]     last_win;
  logic [P_REQ-1:0]  pick_oh;
  logic [SW-1:0]     pick_idx;
  logic              last_unit;
  logic              pad_now;

  rr_pick #(
    .P_REQ     (P_REQ),
    .P_SEL_MSB (P_SEL_MSB)
  ) u_rr_pick (
    .req      (i_req),
    .last_win (last_win),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx)
  );

  assign last_unit = (unit_cnt == CW'(P_UNITS - 1));

`ifdef WR_ARB_N2ONE_PAD_EN
  localparam int STALL_W = clog2(P_ABORT_CYC + 1);

  logic [STALL_W-1:0] stall_cnt;

  // Counts consecutive cycles in BURST without an ack; any ack or leaving BURST clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      stall_cnt <= '0;
    else if (state != ST_BURST || |o_ack)
      stall_cnt <= '0;
    else
      stall_cnt <= stall_cnt + STALL_W'(1);
  end
`endif

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      state    <= ST_IDLE;
      unit_cnt <= '0;
      last_win <= SW'(P_REQ - 1);
      o_gnt    <= '0;
      o_sel    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_BURST) begin
        o_gnt <= pick_oh;
        o_sel <= pick_idx;
      end else if (o_word_done) begin
        o_gnt    <= '0;
        o_sel    <= '0;
        last_win <= o_sel;
      end
      if (o_inc)
        unit_cnt <= last_unit ? '0 : unit_cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|i_req && !i_full) state_nxt = ST_BURST;
      ST_BURST: begin
        if (o_inc && last_unit)
          state_nxt = ST_GAP;
`ifdef WR_ARB_N2ONE_PAD_EN
        else if (!(|o_ack) && stall_cnt == STALL_W'(P_ABORT_CYC - 1))
          state_nxt = ST_PAD;
`endif
      end
`ifdef WR_ARB_N2ONE_PAD_EN
      ST_PAD:   if (last_unit) state_nxt = ST_GAP;
`endif
      ST_GAP:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ack   = '0;
    pad_now = 1'b0;
    if (state == ST_BURST)
      o_ack = o_gnt & i_req;
`ifdef WR_ARB_N2ONE_PAD_EN
    if (state == ST_PAD)
      pad_now = 1'b1;
`endif
    o_inc       = |o_ack || pad_now;
    o_word_done = o_inc && last_unit;
    o_busy      = (state != ST_IDLE);
  end

`ifdef WR_ARB_N2ONE_PAD_EN
  assign o_pad = pad_now;
`endif

endmodule
